// File: rtl/sprite_line_fetcher_if.sv
// Sprite ROM read port plus line-buffer write port shared by the line fetcher.
interface sprite_line_fetcher_if #(
  parameter int ROM_ADDR_WIDTH = 9,
  parameter int COLOR_DEPTH    = 2,
  parameter int IDX_W          = 3
);
  logic                      rom_rd_en;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr;
  logic [COLOR_DEPTH-1:0]    rom_data;
  logic                      buf_wr_en;
  logic                      buf_wr_player;
  logic [IDX_W-1:0]          buf_wr_idx;
  logic [COLOR_DEPTH-1:0]    buf_wr_data;

  modport master (
    output rom_rd_en, rom_addr, buf_wr_en, buf_wr_player, buf_wr_idx, buf_wr_data,
    input  rom_data
  );

  modport slave (
    input  rom_rd_en, rom_addr, buf_wr_en, buf_wr_player, buf_wr_idx, buf_wr_data,
    output rom_data
  );
endinterface

// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite row fetcher: checks both fighters against the upcoming
// line, streams the overlapping sprite rows out of the shared ROM and writes
// them into the matching line buffer. Service order alternates every line.
module sprite_line_fetcher #(
  parameter int SPRITE_WIDTH   = 8,
  parameter int SPRITE_HEIGHT  = 8,
  parameter int FRAME_BITS     = 3,
  parameter int COLOR_DEPTH    = 2,
  parameter int ROM_ADDR_WIDTH = 9
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  line_start,
  input  logic [9:0]            next_line,
  input  logic [9:0]            p0_y,
  input  logic [FRAME_BITS-1:0] p0_sel,
  input  logic [9:0]            p1_y,
  input  logic [FRAME_BITS-1:0] p1_sel,
  sprite_line_fetcher_if.master bus,
  output logic                  p0_line_valid,
  output logic                  p1_line_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int IDX_W = $clog2(SPRITE_WIDTH);
  localparam int ROW_W = $clog2(SPRITE_HEIGHT);

  typedef enum logic [1:0] {IDLE, CHECK, FETCH, DRAIN} state_e;

  state_e                    state_q, state_d;
  logic                      prio_q, prio_d;
  logic                      cur_q, cur_d;
  logic                      second_q, second_d;
  logic [9:0]                line_q, line_d;
  logic [9:0]                y0_q, y0_d, y1_q, y1_d;
  logic [FRAME_BITS-1:0]     sel0_q, sel0_d, sel1_q, sel1_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [IDX_W-1:0]          col_q, col_d;
  logic                      rom_rd_en_q, rom_rd_en_d;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                      buf_wr_en_q, buf_wr_en_d;
  logic                      buf_wr_player_q, buf_wr_player_d;
  logic [IDX_W-1:0]          buf_wr_idx_q, buf_wr_idx_d;
  logic [1:0]                valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;

  logic [9:0]                cur_y;
  logic [FRAME_BITS-1:0]     cur_sel;
  logic [10:0]               l_ext, y_ext;
  logic                      hit;
  logic [ROW_W-1:0]          row_w;
  logic [IDX_W-1:0]          col_inc;

  // Next-state and registered-output computation for the fetch sequencer
  always_comb begin
    state_d         = state_q;
    prio_d          = prio_q;
    cur_d           = cur_q;
    second_d        = second_q;
    line_d          = line_q;
    y0_d            = y0_q;
    y1_d            = y1_q;
    sel0_d          = sel0_q;
    sel1_d          = sel1_q;
    row_d           = row_q;
    col_d           = col_q;
    valid_d         = valid_q;
    rom_rd_en_d     = 1'b0;
    rom_addr_d      = '0;
    // Writes trail reads by one cycle to line up with the ROM data latency.
    buf_wr_en_d     = rom_rd_en_q;
    buf_wr_player_d = rom_rd_en_q ? cur_q : 1'b0;
    buf_wr_idx_d    = rom_rd_en_q ? rom_addr_q[IDX_W-1:0] : '0;
    overrun_d       = line_start && (state_q != IDLE);

    cur_y   = cur_q ? y1_q : y0_q;
    cur_sel = cur_q ? sel1_q : sel0_q;
    // 11-bit compare so y + height cannot wrap past 1023.
    l_ext   = {1'b0, line_q};
    y_ext   = {1'b0, cur_y};
    hit     = (l_ext >= y_ext) && (l_ext < (y_ext + 11'(SPRITE_HEIGHT)));
    row_w   = ROW_W'(line_q - cur_y);
    col_inc = col_q + IDX_W'(1);

    case (state_q)
      IDLE: begin
        if (line_start) begin
          line_d   = next_line;
          y0_d     = p0_y;
          y1_d     = p1_y;
          sel0_d   = p0_sel;
          sel1_d   = p1_sel;
          cur_d    = prio_q;
          prio_d   = ~prio_q;
          second_d = 1'b0;
          valid_d  = '0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (hit) begin
          state_d     = FETCH;
          row_d       = row_w;
          col_d       = '0;
          rom_rd_en_d = 1'b1;
          rom_addr_d  = ROM_ADDR_WIDTH'({cur_sel, row_w, IDX_W'(0)});
        end else if (second_q) begin
          state_d = IDLE;
        end else begin
          cur_d    = ~cur_q;
          second_d = 1'b1;
        end
      end
      FETCH: begin
        if (col_q == IDX_W'(SPRITE_WIDTH - 1)) begin
          state_d = DRAIN;
        end else begin
          col_d       = col_inc;
          rom_rd_en_d = 1'b1;
          rom_addr_d  = ROM_ADDR_WIDTH'({cur_sel, row_q, col_inc});
        end
      end
      DRAIN: begin
        valid_d[cur_q] = 1'b1;
        if (second_q) begin
          state_d = IDLE;
        end else begin
          state_d  = CHECK;
          cur_d    = ~cur_q;
          second_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any job in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      prio_q          <= 1'b0;
      cur_q           <= 1'b0;
      second_q        <= 1'b0;
      line_q          <= '0;
      y0_q            <= '0;
      y1_q            <= '0;
      sel0_q          <= '0;
      sel1_q          <= '0;
      row_q           <= '0;
      col_q           <= '0;
      rom_rd_en_q     <= 1'b0;
      rom_addr_q      <= '0;
      buf_wr_en_q     <= 1'b0;
      buf_wr_player_q <= 1'b0;
      buf_wr_idx_q    <= '0;
      valid_q         <= '0;
      busy_q          <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      prio_q          <= prio_d;
      cur_q           <= cur_d;
      second_q        <= second_d;
      line_q          <= line_d;
      y0_q            <= y0_d;
      y1_q            <= y1_d;
      sel0_q          <= sel0_d;
      sel1_q          <= sel1_d;
      row_q           <= row_d;
      col_q           <= col_d;
      rom_rd_en_q     <= rom_rd_en_d;
      rom_addr_q      <= rom_addr_d;
      buf_wr_en_q     <= buf_wr_en_d;
      buf_wr_player_q <= buf_wr_player_d;
      buf_wr_idx_q    <= buf_wr_idx_d;
      valid_q         <= valid_d;
      busy_q          <= busy_d;
      overrun_q       <= overrun_d;
    end
  end

  assign bus.rom_rd_en     = rom_rd_en_q;
  assign bus.rom_addr      = rom_addr_q;
  assign bus.buf_wr_en     = buf_wr_en_q;
  assign bus.buf_wr_player = buf_wr_player_q;
  assign bus.buf_wr_idx    = buf_wr_idx_q;
  // ROM data arrives in the write cycle itself, so it passes straight through.
  assign bus.buf_wr_data   = buf_wr_en_q ? bus.rom_data : '0;
  assign p0_line_valid     = valid_q[0];
  assign p1_line_valid     = valid_q[1];
  assign busy              = busy_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed and randomised bench for sprite_line_fetcher.
module tb_sprite_line_fetcher;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int FB = 3;
  localparam int CD = 2;
  localparam int AW = 9;
  localparam int IW = 3;
  localparam int unsigned NOPULSE = 99;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          line_start = 1'b0;
  logic [9:0]    next_line = '0;
  logic [9:0]    p0_y = '0;
  logic [9:0]    p1_y = '0;
  logic [FB-1:0] p0_sel = '0;
  logic [FB-1:0] p1_sel = '0;
  logic          p0_line_valid, p1_line_valid, busy, overrun;

  int tests = 0;
  int fails = 0;

  sprite_line_fetcher_if #(.ROM_ADDR_WIDTH(AW), .COLOR_DEPTH(CD), .IDX_W(IW)) bus();

  sprite_line_fetcher #(
    .SPRITE_WIDTH(W), .SPRITE_HEIGHT(H), .FRAME_BITS(FB),
    .COLOR_DEPTH(CD), .ROM_ADDR_WIDTH(AW)
  ) dut (
    .reset(reset), .clk(clk), .line_start(line_start), .next_line(next_line),
    .p0_y(p0_y), .p0_sel(p0_sel), .p1_y(p1_y), .p1_sel(p1_sel),
    .bus(bus),
    .p0_line_valid(p0_line_valid), .p1_line_valid(p1_line_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data = low bits of the address, garbage when not read
  always @(posedge clk) begin
    if (bus.rom_rd_en) bus.rom_data <= bus.rom_addr[CD-1:0];
    else               bus.rom_data <= CD'($urandom);
  end

  // Every write must follow a read one cycle earlier and carry that read's data
  logic          prev_rd = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_rd = 1'b0;
    end else begin
      tests++;
      assert (bus.buf_wr_en === prev_rd) else begin
        fails++;
        $error("FAIL wr_follows_rd: got %0b expected %0b", bus.buf_wr_en, prev_rd);
      end
      if (prev_rd) begin
        tests++;
        assert (bus.buf_wr_data === prev_addr[CD-1:0]) else begin
          fails++;
          $error("FAIL wr_data_tracks_addr: got %0h expected %0h", bus.buf_wr_data, prev_addr[CD-1:0]);
        end
      end
      prev_rd   = bus.rom_rd_en;
      prev_addr = bus.rom_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic vld(input logic p);
    return p ? p1_line_valid : p0_line_valid;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"},   bus.rom_rd_en, 0);
    chk({tag, "_addr"}, bus.rom_addr, 0);
    chk({tag, "_wr"},   bus.buf_wr_en, 0);
    chk({tag, "_pl"},   bus.buf_wr_player, 0);
    chk({tag, "_idx"},  bus.buf_wr_idx, 0);
    chk({tag, "_data"}, bus.buf_wr_data, 0);
    chk({tag, "_v0"},   p0_line_valid, 0);
    chk({tag, "_v1"},   p1_line_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"},  overrun, 0);
  endtask

  // Pulses line_start in cycle T; returns in cycle T+1
  task automatic start_line(input logic [9:0] nl, input logic [9:0] y0, input logic [FB-1:0] s0,
                            input logic [9:0] y1, input logic [FB-1:0] s1);
    next_line = nl; p0_y = y0; p0_sel = s0; p1_y = y1; p1_sel = s1;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_v0", p0_line_valid, 0);
    chk("accept_v1", p1_line_valid, 0);
    chk("accept_rd", bus.rom_rd_en, 0);
  endtask

  // Entered on the first FETCH cycle; returns on the DRAIN cycle
  task automatic expect_fetch(input string tag, input int unsigned base, input logic pl,
                              input int unsigned pulse);
    for (int unsigned i = 0; i < W; i++) begin
      chk({tag, "_rd"}, bus.rom_rd_en, 1);
      chk({tag, "_addr"}, bus.rom_addr, base + i);
      if (i > 0) begin
        chk({tag, "_wr"}, bus.buf_wr_en, 1);
        chk({tag, "_pl"}, bus.buf_wr_player, pl);
        chk({tag, "_idx"}, bus.buf_wr_idx, i - 1);
        chk({tag, "_data"}, bus.buf_wr_data, (base + i - 1) % 4);
      end
      chk({tag, "_ovr"}, overrun, (pulse != NOPULSE) && (i == pulse + 1));
      if (i == pulse) begin
        line_start = 1'b1;
        next_line  = next_line + 10'd1;
        p0_y       = p0_y ^ 10'h155;
        p1_y       = p1_y ^ 10'h0aa;
        p0_sel     = ~p0_sel;
        p1_sel     = ~p1_sel;
      end
      tick();
      line_start = 1'b0;
    end
    chk({tag, "_drain_rd"}, bus.rom_rd_en, 0);
    chk({tag, "_drain_wr"}, bus.buf_wr_en, 1);
    chk({tag, "_drain_pl"}, bus.buf_wr_player, pl);
    chk({tag, "_drain_idx"}, bus.buf_wr_idx, 7);
    chk({tag, "_drain_data"}, bus.buf_wr_data, (base + 7) % 4);
    chk({tag, "_drain_busy"}, busy, 1);
    chk({tag, "_drain_ovr"}, overrun, (pulse != NOPULSE) && (W == pulse + 1));
  endtask

  // Entered at T+1 of a line where both fighters hit; returns at T+21
  task automatic two_hit(input string tag, input int unsigned base_a, input logic pa,
                         input int unsigned base_b, input logic pb, input int unsigned pulse);
    tick();
    expect_fetch({tag, "_a"}, base_a, pa, pulse);
    tick();
    chk({tag, "_t11_va"}, vld(pa), 1);
    chk({tag, "_t11_vb"}, vld(pb), 0);
    chk({tag, "_t11_busy"}, busy, 1);
    chk({tag, "_t11_rd"}, bus.rom_rd_en, 0);
    tick();
    expect_fetch({tag, "_b"}, base_b, pb, NOPULSE);
    tick();
    chk({tag, "_t21_va"}, vld(pa), 1);
    chk({tag, "_t21_vb"}, vld(pb), 1);
    chk({tag, "_t21_busy"}, busy, 0);
  endtask

  // Entered at T+1 of a line where neither fighter hits
  task automatic zero_hit(input string tag);
    tick();
    chk({tag, "_t2_busy"}, busy, 1);
    chk({tag, "_t2_rd"}, bus.rom_rd_en, 0);
    tick();
    chk({tag, "_t3_busy"}, busy, 0);
    chk({tag, "_t3_v0"}, p0_line_valid, 0);
    chk({tag, "_t3_v1"}, p1_line_valid, 0);
    chk({tag, "_t3_wr"}, bus.buf_wr_en, 0);
  endtask

  initial begin
    logic [9:0] nl, y0, y1;
    logic       h0, h1;
    int unsigned guard;

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();
    tick();

    // Single hit: p0 row 3 of frame 2, p1 far away
    start_line(10'd103, 10'd100, 3'd2, 10'd300, 3'd0);
    tick();
    expect_fetch("t1", 152, 1'b0, NOPULSE);
    tick();
    chk("t1_t11_v0", p0_line_valid, 1);
    chk("t1_t11_v1", p1_line_valid, 0);
    chk("t1_t11_busy", busy, 1);
    tick();
    tick();
    chk("t1_t13_busy", busy, 0);
    chk("t1_t13_v0", p0_line_valid, 1);
    chk("t1_t13_v1", p1_line_valid, 0);

    // Reset restores prio so the next line serves player 0 first
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Two hits on consecutive lines; order alternates
    start_line(10'd207, 10'd200, 3'd1, 10'd200, 3'd5);
    two_hit("t2a", 120, 1'b0, 376, 1'b1, NOPULSE);
    start_line(10'd207, 10'd200, 3'd1, 10'd200, 3'd5);
    two_hit("t2b", 376, 1'b1, 120, 1'b0, NOPULSE);

    // Boundaries around py=50 (prio now 0)
    start_line(10'd49, 10'd50, 3'd3, 10'd600, 3'd0);
    zero_hit("above");
    start_line(10'd50, 10'd50, 3'd3, 10'd600, 3'd0);    // p1 checked first
    tick();
    chk("row0_t2_busy", busy, 1);
    chk("row0_t2_rd", bus.rom_rd_en, 0);
    tick();
    expect_fetch("row0", 192, 1'b0, NOPULSE);
    tick();
    chk("row0_t12_v0", p0_line_valid, 1);
    chk("row0_t12_v1", p1_line_valid, 0);
    chk("row0_t12_busy", busy, 0);
    start_line(10'd57, 10'd50, 3'd3, 10'd600, 3'd0);    // p0 checked first
    tick();
    expect_fetch("row7", 248, 1'b0, NOPULSE);
    tick();
    chk("row7_t11_v0", p0_line_valid, 1);
    chk("row7_t11_busy", busy, 1);
    tick();
    chk("row7_t12_busy", busy, 0);
    chk("row7_t12_v1", p1_line_valid, 0);
    start_line(10'd58, 10'd50, 3'd3, 10'd600, 3'd0);
    zero_hit("below");
    start_line(10'd3, 10'd1020, 3'd4, 10'd1020, 3'd4);
    zero_hit("nowrap");

    // Overrun during a two-hit job (p1 first); inputs scrambled mid-job
    start_line(10'd207, 10'd200, 3'd1, 10'd200, 3'd5);
    two_hit("ovr", 376, 1'b1, 120, 1'b0, 3);

    // Reset mid-FETCH at T+6
    start_line(10'd207, 10'd200, 3'd1, 10'd200, 3'd5);
    repeat (5) tick();
    chk("mid_t6_rd", bus.rom_rd_en, 1);
    chk("mid_t6_addr", bus.rom_addr, 124);
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    chk_all_zero("held_rst");
    tick();
    reset = 1'b1;
    tick();
    start_line(10'd103, 10'd100, 3'd2, 10'd100, 3'd6);
    two_hit("post_rst", 152, 1'b0, 408, 1'b1, NOPULSE);

    // Random lines; write/read correspondence checked on every cycle
    for (int unsigned n = 0; n < 1000; n++) begin
      nl = 10'($urandom_range(0, 1023));
      y0 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                       : 10'(int'(nl) + 1024 + 2 - int'($urandom_range(0, 12)));
      y1 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                       : 10'(int'(nl) + 1024 + 2 - int'($urandom_range(0, 12)));
      h0 = (int'(nl) >= int'(y0)) && (int'(nl) < int'(y0) + H);
      h1 = (int'(nl) >= int'(y1)) && (int'(nl) < int'(y1) + H);
      start_line(nl, y0, FB'($urandom), y1, FB'($urandom));
      guard = 0;
      while (busy && guard < 40) begin
        tick();
        guard++;
      end
      chk("rand_done", busy, 0);
      chk("rand_v0", p0_line_valid, h0);
      chk("rand_v1", p1_line_valid, h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_line_fetcher.md
Name: sprite_line_fetcher

Overview:
Per-scanline controller that shares one synchronous sprite ROM between the two fighter renderers. On each horizontal-blank start it decides which fighters overlap the upcoming scanline. For each fighter that overlaps, it sequences ROM reads for that sprite row and writes the pixels into that fighter's line buffer. Player order alternates every line so neither fighter is always served last. It sits between the VGA timing generator and the sprite renderers.

Parameters:
SPRITE_WIDTH, 8, pixels per sprite row; power of two
SPRITE_HEIGHT, 8, rows per sprite frame; power of two
FRAME_BITS, 3, width of a frame select; ROM holds 2**FRAME_BITS frames
COLOR_DEPTH, 2, bits per pixel colour code
ROM_ADDR_WIDTH, 9, FRAME_BITS + log2(SPRITE_HEIGHT) + log2(SPRITE_WIDTH)

Ports:
reset  in  1  asynchronous, active-low
clk  in  1  pixel clock
line_start  in  1  one-cycle pulse at hblank start
next_line  in  10  ycoord of the scanline to prepare
p0_y  in  10  top row of fighter 0 sprite
p0_sel  in  FRAME_BITS  fighter 0 frame select
p1_y  in  10  top row of fighter 1 sprite
p1_sel  in  FRAME_BITS  fighter 1 frame select
rom_rd_en  out  1  ROM read strobe
rom_addr  out  ROM_ADDR_WIDTH  ROM address
rom_data  in  COLOR_DEPTH  ROM data, valid exactly 1 cycle after rom_rd_en
buf_wr_en  out  1  line-buffer write strobe
buf_wr_player  out  1  target buffer (0/1)
buf_wr_idx  out  log2(SPRITE_WIDTH)  pixel column within row
buf_wr_data  out  COLOR_DEPTH  pixel colour code
p0_line_valid  out  1  fighter 0 buffer holds a complete row for the current line
p1_line_valid  out  1  as above, fighter 1
busy  out  1  job in progress
overrun  out  1  one-cycle pulse: line_start arrived while busy

Behaviour:
- Reset (asynchronous, active-low): all outputs 0; state IDLE; priority bit prio=0; latched inputs cleared. Reset mid-job aborts the job immediately. No write occurs after reset asserts.
- States: IDLE, CHECK, FETCH, DRAIN.
- Acceptance: line_start=1 in IDLE latches next_line, p0_y/p0_sel, p1_y/p1_sel. It sets first=prio and toggles prio. On the next cycle it enters CHECK for player `first`, clears both line_valid bits, and raises busy.
- Overrun: line_start outside IDLE is ignored and pulses overrun for 1 cycle. The job in progress continues unaffected.
- CHECK (1 cycle) for player p: hit = (L >= py) && (L < py + SPRITE_HEIGHT), with L = next_line.
  - The comparison is done in 11-bit unsigned arithmetic so that py+SPRITE_HEIGHT does not wrap.
  - row = (L - py)[log2(SPRITE_HEIGHT)-1:0].
  - If hit: go to FETCH, col=0.
  - If not hit: go to CHECK for the other player, or to IDLE if both are done. That player's valid stays 0.
- FETCH (SPRITE_WIDTH cycles):
  - rom_rd_en=1.
  - rom_addr = {sel, row, col}, i.e. sel*W*H + row*W + col.
  - col increments 0..W-1, then the state goes to DRAIN.
- Write pipeline: every cycle after a rom_rd_en cycle, buf_wr_en=1, buf_wr_player=p, buf_wr_idx = col of that read, buf_wr_data = rom_data. Writes occur only in those cycles.
- DRAIN (1 cycle): the final write happens here. p's line_valid goes high on the following cycle. Next state is CHECK of the other player, or IDLE.
- busy is high in CHECK, FETCH and DRAIN, and low in IDLE.
- line_valid bits stay high until the next accepted line_start or reset.
- Timing, two hits, W=8, line_start at cycle T:
  - CHECK T+1; FETCH T+2..T+9 (writes T+3..T+10); DRAIN T+10.
  - CHECK T+11; FETCH T+12..T+19; DRAIN T+20.
  - first player's valid high from T+11; second player's from T+21; IDLE and busy=0 at T+21.
  - Zero hits: busy high T+1..T+2; IDLE at T+3.
- Boundaries:
  - L == py+SPRITE_HEIGHT-1 is a hit (row=7).
  - L == py+SPRITE_HEIGHT is a miss.
  - py > L is a miss (no negative wrap).
  - py=1020, L=3 is a miss.
  - Inputs changing during a job have no effect; only the latched values are used.

Test Plan:
- Reset, then p0_y=100, p0_sel=2, p1_y=300, line_start with next_line=103 -> rom_addr 2*64+3*8+0..7 = 152..159 on T+2..T+9. Writes to player 0 idx 0..7 on T+3..T+10. p0_line_valid=1 at T+11, p1_line_valid=0, busy=0 at T+13.
- Both fighters at y=200, sel 1 and 5, next_line=207, two consecutive lines -> first line serves p0 (addrs 120..127), then p1 (376..383). Second line serves p1 first. p1 valid at T+11 on the second line.
- Boundary rows: next_line = py-1, py, py+7, py+8 with py=50 -> hits only at py and py+7. Row 0 and row 7 addresses are exact.
- line_start at T+5 during a two-hit job -> overrun=1 for exactly 1 cycle. Address and write sequence identical to the no-overrun run. Completion still at T+21.
- Assert reset at T+6 mid-FETCH -> all outputs 0 next edge, no further writes. A subsequent line_start runs a clean job with prio=0 (player 0 first).
- ROM model returns data = low bits of address -> every buf_wr_data matches the address issued one cycle earlier, across 1000 random y/sel/next_line lines. No write without a preceding read.
